// File: rtl/fft_pkg.sv
// Shared FFT datapath constants: component width, complex-word width and
// the complex multiplier latency that the butterfly X path is matched to.
package fft_pkg;
  localparam int WORD_SIZE = 16;
  localparam int CPLX_W    = 2 * WORD_SIZE;
  localparam int CMULT_LAT = 3;
endpackage

// File: rtl/cplx_delay.sv
// Fixed-depth shift register carrying a data word and its valid bit,
// cleared asynchronously so no stale word survives a reset.
module cplx_delay #(
  parameter int width = 32,
  parameter int depth = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [width-1:0] data,
  output logic             dly_valid,
  output logic [width-1:0] dly_data
);

  logic [width-1:0] pipe [depth];
  logic [depth-1:0] vpipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vpipe <= '0;
      for (int i = 0; i < depth; i++)
        pipe[i] <= '0;
    end else begin
      vpipe[0] <= valid;
      pipe[0]  <= data;
      for (int i = 1; i < depth; i++) begin
        vpipe[i] <= vpipe[i-1];
        pipe[i]  <= pipe[i-1];
      end
    end
  end

  assign dly_valid = vpipe[depth-1];
  assign dly_data  = pipe[depth-1];

endmodule

// File: rtl/bfly_combine.sv
// Radix-2 butterfly combine: Y0 = X+P, Y1 = X-P with X delayed to meet P.
// BFLY_SCALE_EN selects round-half-up /2 scaling instead of saturation.
module bfly_combine
  import fft_pkg::*;
#(
  parameter int word_size = WORD_SIZE,
  parameter int LAT       = CMULT_LAT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [2*word_size-1:0] X,
  input  logic                   p_valid,
  input  logic [2*word_size-1:0] P,
  input  logic                   ovf_clr,
  output logic                   o_valid,
  output logic [2*word_size-1:0] Y0,
  output logic [2*word_size-1:0] Y1,
  output logic                   o_ovf,
  output logic                   o_err
);

  localparam int W  = word_size;
  localparam int CW = 2 * word_size;

  logic          xv;
  logic [CW-1:0] xd;

  cplx_delay #(
    .width (CW),
    .depth (LAT)
  ) u_xdly (
    .clk       (clk),
    .reset     (reset),
    .valid     (i_valid),
    .data      (X),
    .dly_valid (xv),
    .dly_data  (xd)
  );

  // Result packs {overflow, component}.
  function automatic logic [W:0] reduce(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         sub
  );
    logic [W:0] s;
`ifdef BFLY_SCALE_EN
    logic [W:0] r;
`endif
    s = sub ? ({a[W-1], a} - {b[W-1], b})
            : ({a[W-1], a} + {b[W-1], b});
`ifdef BFLY_SCALE_EN
    r = s + {{W{1'b0}}, 1'b1};
    return {1'b0, r[W:1]};
`else
    if (s[W] != s[W-1])
      return {1'b1, s[W], {(W-1){~s[W]}}};
    else
      return {1'b0, s[W-1:0]};
`endif
  endfunction

  logic       combine;
  logic       misalign;
  logic       sat;
  logic [W:0] s0r, s0i, s1r, s1i;

  always_comb begin
    combine  = p_valid & xv;
    misalign = p_valid ^ xv;
    s0r = reduce(xd[CW-1:W], P[CW-1:W], 1'b0);
    s0i = reduce(xd[W-1:0],  P[W-1:0],  1'b0);
    s1r = reduce(xd[CW-1:W], P[CW-1:W], 1'b1);
    s1i = reduce(xd[W-1:0],  P[W-1:0],  1'b1);
    sat = combine & (s0r[W] | s0i[W] | s1r[W] | s1i[W]);
  end

  // Flags are sticky; a new event in the clear cycle keeps them set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_valid <= 1'b0;
      Y0      <= '0;
      Y1      <= '0;
      o_ovf   <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= combine;
      if (combine) begin
        Y0 <= {s0r[W-1:0], s0i[W-1:0]};
        Y1 <= {s1r[W-1:0], s1i[W-1:0]};
      end
      o_ovf <= sat | (o_ovf & ~ovf_clr);
      o_err <= misalign | (o_err & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_bfly_combine.sv
// Directed bench for bfly_combine (word_size=16, LAT=3), both builds.
// Expected values are hand-computed; the ramp stream uses a small model.
module tb_bfly_combine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] X = '0;
  logic        p_valid = 1'b0;
  logic [31:0] P = '0;
  logic        ovf_clr = 1'b0;
  logic        o_valid;
  logic [31:0] Y0;
  logic [31:0] Y1;
  logic        o_ovf;
  logic        o_err;

  int n_tests = 0;
  int n_fail  = 0;

  bfly_combine dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .X       (X),
    .p_valid (p_valid),
    .P       (P),
    .ovf_clr (ovf_clr),
    .o_valid (o_valid),
    .Y0      (Y0),
    .Y1      (Y1),
    .o_ovf   (o_ovf),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // X enters at E0, P meets it at E3; outputs visible after E3.
  task automatic xact(
    input logic [31:0] x,
    input logic [31:0] p,
    input logic        clr
  );
    i_valid = 1'b1;
    X = x;
    step();
    i_valid = 1'b0;
    step();
    step();
    p_valid = 1'b1;
    P = p;
    ovf_clr = clr;
    step();
    p_valid = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic clear_flags();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
  endtask

  function automatic logic [15:0] model(
    input logic [15:0] a,
    input logic [15:0] b,
    input bit          sub
  );
    int s;
    s = sub ? ($signed(a) - $signed(b)) : ($signed(a) + $signed(b));
`ifdef BFLY_SCALE_EN
    s = (s + 1) >>> 1;
`else
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  function automatic logic [31:0] ramp_x(input int k);
    return {16'(k * 256), 16'(-k * 128)};
  endfunction

  function automatic logic [31:0] ramp_p(input int k);
    return {16'(k * 64 + 5), 16'(k * 16)};
  endfunction

  logic [31:0] e0, e1;

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {o_valid, Y0, Y1, o_ovf, o_err}, '0);
    reset = 1'b1;
    step();

    // basic
    xact({16'h2000, 16'h1000}, {16'h1000, 16'h0800}, 1'b0);
`ifdef BFLY_SCALE_EN
    check("basic_y", {o_valid, Y0, Y1}, {1'b1, 32'h1800_0C00, 32'h0800_0400});
`else
    check("basic_y", {o_valid, Y0, Y1}, {1'b1, 32'h3000_1800, 32'h1000_0800});
`endif
    check("basic_flags", {o_ovf, o_err}, 2'b00);
    step();
    check("basic_bubble", o_valid, 1'b0);

    // saturation case 1
    xact({16'h7000, 16'h0}, {16'h7000, 16'h0}, 1'b0);
`ifdef BFLY_SCALE_EN
    check("sat1_y", {Y0, Y1}, {32'h7000_0000, 32'h0});
    check("sat1_ovf", o_ovf, 1'b0);
`else
    check("sat1_y", {Y0, Y1}, {32'h7FFF_0000, 32'h0});
    check("sat1_ovf", o_ovf, 1'b1);
    step();
    check("sat1_sticky", {o_valid, o_ovf}, 2'b01);
`endif
    clear_flags();
    check("ovf_clr", o_ovf, 1'b0);

    // saturation case 2, with clear in the same cycle (set wins)
    xact({16'h8000, 16'h0}, {16'h0001, 16'h0}, 1'b1);
`ifdef BFLY_SCALE_EN
    check("sat2_y1r", Y1[31:16], 16'hC000);
    check("sat2_ovf", o_ovf, 1'b0);
`else
    check("sat2_y1r", Y1[31:16], 16'h8000);
    check("sat2_ovf_setwins", o_ovf, 1'b1);
`endif
    clear_flags();

    // rounding vectors
    xact({16'h0001, 16'h0}, 32'h0, 1'b0);
    check("rnd_p1", Y0[31:16], 16'h0001);
    xact({16'hFFFF, 16'h0}, 32'h0, 1'b0);
`ifdef BFLY_SCALE_EN
    check("rnd_m1", Y0[31:16], 16'h0000);
`else
    check("rnd_m1", Y0[31:16], 16'hFFFF);
`endif
    xact({16'hFFFD, 16'h0}, 32'h0, 1'b0);
`ifdef BFLY_SCALE_EN
    check("rnd_m3", Y0[31:16], 16'hFFFF);
`else
    check("rnd_m3", Y0[31:16], 16'hFFFD);
`endif
    check("rnd_noerr", {o_ovf, o_err}, 2'b00);

    // alignment: lone p_valid
    step();
    p_valid = 1'b1;
    step();
    p_valid = 1'b0;
    check("align_p_only", {o_valid, o_err}, 2'b01);
    clear_flags();
    check("err_clr", o_err, 1'b0);

    // alignment: lone i_valid
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    step();
    check("align_pre", o_err, 1'b0);
    step();
    check("align_x_only", {o_valid, o_err}, 2'b01);
    clear_flags();

    // streaming ramp
    for (int c = 0; c < 19; c++) begin
      i_valid = (c < 16);
      X = ramp_x(c);
      p_valid = (c >= 3);
      P = ramp_p(c - 3);
      step();
      if (c >= 3) begin
        e0 = {model(ramp_x(c-3)>>16, ramp_p(c-3)>>16, 0),
              model(ramp_x(c-3) & 32'hFFFF, ramp_p(c-3) & 32'hFFFF, 0)};
        e1 = {model(ramp_x(c-3)>>16, ramp_p(c-3)>>16, 1),
              model(ramp_x(c-3) & 32'hFFFF, ramp_p(c-3) & 32'hFFFF, 1)};
        check($sformatf("stream_%0d", c - 3), {o_valid, Y0, Y1},
              {1'b1, e0, e1});
      end
    end
    i_valid = 1'b0;
    p_valid = 1'b0;
    step();
    check("stream_end", {o_valid, o_err}, 2'b00);

    // reset mid-stream
    xact({16'h7000, 16'h0}, {16'h7000, 16'h0}, 1'b0);
    i_valid = 1'b1;
    X = {16'h1234, 16'h5678};
    step();
    i_valid = 1'b0;
    step();
    #2 reset = 1'b0;
    #1;
    check("rst_async", {o_valid, Y0, Y1, o_ovf, o_err}, '0);
    @(posedge clk);
    #1 reset = 1'b1;
    p_valid = 1'b1;
    P = {16'h0100, 16'h0100};
    step();
    p_valid = 1'b0;
    check("rst_no_valid", {o_valid, Y0, Y1}, '0);
    step();
    check("rst_still_idle", o_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
